// File: rtl/beep_sched.sv
// Buzzer arbiter: alert > click > background music, with internally generated
// click/alert tones and a forced silent gap on every hand-over.
module beep_sched #(
   parameter int CLK_PRE     = 50_000_000,
   parameter int CLICK_DIV   = 25_000,
   parameter int CLICK_TIME  = 2_500_000,
   parameter int ALERT_DIV   = 50_000,
   parameter int ALERT_ON    = 10_000_000,
   parameter int ALERT_OFF   = 5_000_000,
   parameter int ALERT_BEEPS = 3,
   parameter int GAP_TIME    = 500_000,
   parameter int DUTY_SHIFT  = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       click_req,
   input  logic       alert_req,
   input  logic       bgm_req,
   input  logic       bgm_pwm,
   output logic       bgm_flag,
   output logic       pwm,
   output logic [1:0] grant,
   output logic       busy
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int DUR_MAX = max2(max2(CLICK_TIME, ALERT_ON), max2(ALERT_OFF, GAP_TIME));
   localparam int DW      = $clog2(DUR_MAX + 1);
   localparam int TW      = $clog2(max2(CLICK_DIV, ALERT_DIV) + 1);

   localparam logic [TW-1:0] CLICK_LAST = TW'(CLICK_DIV - 1);
   localparam logic [TW-1:0] ALERT_LAST = TW'(ALERT_DIV - 1);
   localparam logic [TW-1:0] CLICK_LOW  = TW'(CLICK_DIV >> DUTY_SHIFT);
   localparam logic [TW-1:0] ALERT_LOW  = TW'(ALERT_DIV >> DUTY_SHIFT);
   localparam logic [DW-1:0] CLICK_END  = DW'(CLICK_TIME - 1);
   localparam logic [DW-1:0] ON_END     = DW'(ALERT_ON - 1);
   localparam logic [DW-1:0] OFF_END    = DW'(ALERT_OFF - 1);
   localparam logic [DW-1:0] GAP_END    = DW'(GAP_TIME - 1);
   localparam logic [3:0]    BEEP_END   = 4'(ALERT_BEEPS - 1);

   if (CLK_PRE < 1 || ALERT_BEEPS < 1 || ALERT_BEEPS > 15) begin : g_param_err
      $error("beep_sched: illegal parameter value");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLICK,
      S_ALERT,
      S_BGM,
      S_GAP
   } state_e;

   state_e          state_q, state_d;
   state_e          pick;
   logic            click_pend_q, click_pend_d;
   logic            alert_pend_q, alert_pend_d;
   logic [DW-1:0]   dcnt_q, dcnt_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [3:0]      bcnt_q, bcnt_d;
   logic            on_q, on_d;
   logic            pwm_q, pwm_d;
   logic            bgm_flag_q, bgm_flag_d;
   logic [1:0]      grant_q, grant_d;
   logic            busy_q, busy_d;
   logic            entry;

   // Next state; IDLE and the end of GAP share the same priority pick.
   always_comb begin
      pick = S_IDLE;
      if (alert_pend_q)      pick = S_ALERT;
      else if (click_pend_q) pick = S_CLICK;
      else if (bgm_req)      pick = S_BGM;

      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = pick;
         S_CLICK: if (dcnt_q == CLICK_END) state_d = S_GAP;
         S_ALERT: if (!on_q && dcnt_q == OFF_END && bcnt_q == BEEP_END) state_d = S_GAP;
         S_BGM: begin
            if (click_pend_q || alert_pend_q) state_d = S_GAP;
            else if (!bgm_req)                state_d = S_IDLE;
         end
         S_GAP:   if (dcnt_q == GAP_END) state_d = pick;
         default: state_d = S_IDLE;
      endcase
   end

   // Duration, tone and beep counters; every state entry restarts them.
   always_comb begin
      entry  = (state_d != state_q);
      dcnt_d = dcnt_q;
      tcnt_d = tcnt_q;
      bcnt_d = bcnt_q;
      on_d   = on_q;
      if (entry) begin
         dcnt_d = '0;
         tcnt_d = '0;
         bcnt_d = '0;
         on_d   = 1'b1;
      end else begin
         case (state_q)
            S_CLICK: begin
               dcnt_d = dcnt_q + 1'b1;
               tcnt_d = (tcnt_q == CLICK_LAST) ? '0 : tcnt_q + 1'b1;
            end
            S_ALERT: begin
               if (on_q) begin
                  if (dcnt_q == ON_END) begin
                     on_d   = 1'b0;
                     dcnt_d = '0;
                  end else begin
                     dcnt_d = dcnt_q + 1'b1;
                     tcnt_d = (tcnt_q == ALERT_LAST) ? '0 : tcnt_q + 1'b1;
                  end
               end else if (dcnt_q == OFF_END) begin
                  bcnt_d = bcnt_q + 1'b1;
                  on_d   = 1'b1;
                  dcnt_d = '0;
                  tcnt_d = '0;
               end else begin
                  dcnt_d = dcnt_q + 1'b1;
               end
            end
            S_GAP:   dcnt_d = dcnt_q + 1'b1;
            default: ;
         endcase
      end
   end

   // A request landing on the entry cycle of its own state is dropped.
   always_comb begin
      click_pend_d = click_pend_q | (click_req && state_q != S_CLICK);
      alert_pend_d = alert_pend_q | (alert_req && state_q != S_ALERT);
      if (state_d == S_CLICK && state_q != S_CLICK) click_pend_d = 1'b0;
      if (state_d == S_ALERT && state_q != S_ALERT) alert_pend_d = 1'b0;
   end

   always_comb begin
      pwm_d = 1'b1;
      case (state_q)
         S_CLICK: pwm_d = !(tcnt_q < CLICK_LOW);
         S_ALERT: pwm_d = !(on_q && tcnt_q < ALERT_LOW);
         S_BGM:   pwm_d = bgm_pwm;
         default: pwm_d = 1'b1;
      endcase
      case (state_d)
         S_CLICK: grant_d = 2'd1;
         S_ALERT: grant_d = 2'd2;
         S_BGM:   grant_d = 2'd3;
         default: grant_d = 2'd0;
      endcase
      busy_d     = (state_d != S_IDLE);
      bgm_flag_d = (state_d == S_BGM);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         click_pend_q <= 1'b0;
         alert_pend_q <= 1'b0;
         dcnt_q       <= '0;
         tcnt_q       <= '0;
         bcnt_q       <= '0;
         on_q         <= 1'b0;
         pwm_q        <= 1'b1;
         bgm_flag_q   <= 1'b0;
         grant_q      <= 2'd0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         click_pend_q <= click_pend_d;
         alert_pend_q <= alert_pend_d;
         dcnt_q       <= dcnt_d;
         tcnt_q       <= tcnt_d;
         bcnt_q       <= bcnt_d;
         on_q         <= on_d;
         pwm_q        <= pwm_d;
         bgm_flag_q   <= bgm_flag_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
      end
   end

   assign pwm      = pwm_q;
   assign bgm_flag = bgm_flag_q;
   assign grant    = grant_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_beep_sched.sv
// Directed-sequence bench for beep_sched with randomized timing/patterns,
// expected waveforms computed arithmetically from the tone/beep rules.
module tb_beep_sched;
   localparam int CD   = 8;
   localparam int CT   = 32;
   localparam int AD   = 16;
   localparam int AON  = 48;
   localparam int AOFF = 16;
   localparam int AB   = 2;
   localparam int GT   = 4;
   localparam int DS   = 1;
   localparam int ALEN = AB * (AON + AOFF);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       click_req = 1'b0;
   logic       alert_req = 1'b0;
   logic       bgm_req = 1'b0;
   logic       bgm_pwm = 1'b0;
   logic       bgm_flag;
   logic       pwm;
   logic [1:0] grant;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   beep_sched #(
      .CLK_PRE(50_000_000), .CLICK_DIV(CD), .CLICK_TIME(CT), .ALERT_DIV(AD),
      .ALERT_ON(AON), .ALERT_OFF(AOFF), .ALERT_BEEPS(AB), .GAP_TIME(GT), .DUTY_SHIFT(DS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .click_req(click_req), .alert_req(alert_req),
      .bgm_req(bgm_req), .bgm_pwm(bgm_pwm), .bgm_flag(bgm_flag), .pwm(pwm),
      .grant(grant), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic c, input logic a);
      click_req = c;
      alert_req = a;
      tick();
      click_req = 1'b0;
      alert_req = 1'b0;
   endtask

   // Tone: low for the first div>>DS cycles of every div-cycle period.
   function automatic logic tone_pwm(input int i, input int div);
      return ((i % div) < (div >> DS)) ? 1'b0 : 1'b1;
   endfunction

   function automatic logic alert_pwm(input int i);
      int k;
      k = i % (AON + AOFF);
      return (k < AON) ? tone_pwm(k, AD) : 1'b1;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int m, low;
      logic r;
      repeat (2) tick();
      chk("rst_pwm", pwm, 1);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flag", bgm_flag, 0);
      rst_n = 1'b1;
      tick();

      // single click
      pulse(1, 0);
      chk("click_pending_grant", grant, 0);
      tick();
      chk("click_grant", grant, 1);
      chk("click_busy", busy, 1);
      for (int i = 0; i < CT; i++) begin
         tick();
         chk("click_pwm", pwm, tone_pwm(i, CD));
      end
      chk("click_gap_grant", grant, 0);
      chk("click_gap_busy", busy, 1);
      repeat (GT - 1) begin
         tick();
         chk("click_gap_pwm", pwm, 1);
         chk("click_gap_busy2", busy, 1);
      end
      tick();
      chk("click_idle_busy", busy, 0);

      // single alert
      repeat ($urandom_range(1, 5)) tick();
      pulse(0, 1);
      tick();
      chk("alert_grant", grant, 2);
      for (int i = 0; i < ALEN; i++) begin
         tick();
         chk("alert_pwm", pwm, alert_pwm(i));
      end
      chk("alert_gap_grant", grant, 0);
      chk("alert_gap_busy", busy, 1);
      repeat (GT) tick();
      chk("alert_idle_busy", busy, 0);

      // background music passthrough
      bgm_req = 1'b1;
      tick();
      chk("bgm_flag_on", bgm_flag, 1);
      chk("bgm_grant", grant, 3);
      for (int i = 0; i < 40; i++) begin
         r = 1'($urandom_range(0, 1));
         bgm_pwm = r;
         tick();
         chk("bgm_pwm_delay", pwm, r);
      end
      bgm_pwm = 1'b0;
      bgm_req = 1'b0;
      tick();
      chk("bgm_drop_flag", bgm_flag, 0);
      chk("bgm_drop_busy", busy, 0);
      tick();
      chk("bgm_idle_pwm", pwm, 1);

      // click interrupts background music
      bgm_req = 1'b1;
      tick();
      chk("bgm2_flag", bgm_flag, 1);
      repeat ($urandom_range(1, 10)) tick();
      pulse(1, 0);
      chk("bgm2_flag_before_gap", bgm_flag, 1);
      tick();
      low = 0;
      for (int k = 0; k < 200 && bgm_flag == 1'b0; k++) begin
         low++;
         tick();
      end
      chk("bgm2_low_cycles", low, GT + CT + GT);
      chk("bgm2_resume_flag", bgm_flag, 1);
      chk("bgm2_resume_grant", grant, 3);
      bgm_req = 1'b0;
      tick();
      chk("bgm2_idle_busy", busy, 0);

      // simultaneous click and alert: alert first
      pulse(1, 1);
      tick();
      chk("both_alert_first", grant, 2);
      repeat (ALEN) tick();
      chk("both_gap", grant, 0);
      repeat (GT) tick();
      chk("both_click_second", grant, 1);
      repeat (CT) tick();
      chk("both_gap2", grant, 0);
      repeat (GT) tick();
      chk("both_idle_busy", busy, 0);

      // click during click ignored, alert during click waits
      pulse(1, 0);
      tick();
      chk("pend_click_grant", grant, 1);
      m = $urandom_range(1, 20);
      repeat (m) tick();
      pulse(1, 1);
      repeat (CT + GT - m - 1) tick();
      chk("pend_alert_after_click", grant, 2);
      repeat (ALEN) tick();
      chk("pend_alert_gap", grant, 0);
      repeat (GT) tick();
      chk("pend_click_dropped", busy, 0);

      // reset in the middle of an alert tone-low phase
      pulse(0, 1);
      tick();
      chk("rst_alert_grant", grant, 2);
      m = 1 + AD * $urandom_range(0, 2);
      repeat (m) tick();
      chk("rst_pre_pwm_low", pwm, 0);
      rst_n = 1'b0;
      #1;
      chk("rst_async_pwm", pwm, 1);
      chk("rst_async_grant", grant, 0);
      chk("rst_async_busy", busy, 0);
      chk("rst_async_flag", bgm_flag, 0);
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("rst_no_resume_busy", busy, 0);
      chk("rst_no_resume_grant", grant, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
